// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, received word plus status out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 serialIn;
  logic [DATA_BITS-1:0] rxData;
  logic                 rxValid;
  logic                 rxReady;
  logic                 parityErr;
  logic                 frameErr;
  logic                 overrunErr;
  logic                 busy;

  modport master (
    input  serialIn, rxReady,
    output rxData, rxValid, parityErr, frameErr, overrunErr, busy
  );

  modport slave (
    output serialIn, rxReady,
    input  rxData, rxValid, parityErr, frameErr, overrunErr, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-of-3 mid-bit voting, optional parity,
// 1 or 2 stop bits, valid/ready hold register with sticky overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic             sampleClk,
  input logic             rst_b,
  uart_rx_param_if.master rx
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CW-1:0] CNT_PRE   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(H);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
  localparam logic          HAS_PAR   = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic          ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [2:0]    AFTER_DAT = HAS_PAR ? PARITY : STOP;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p,
                                      input logic odd);
    return ((^d) ^ p) != odd;
  endfunction

  logic                 sync1_r, sync2_r;
  logic [1:0]           fill_r;
  logic                 armed_r;
  logic [2:0]           state_r, state_nxt;
  logic [CW-1:0]        cnt_r, cnt_nxt;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_nxt;
  logic                 stop_idx_r, stop_idx_nxt;
  logic [DATA_BITS-1:0] shift_r, shift_nxt;
  logic                 par_pend_r, par_pend_nxt;
  logic                 frm_pend_r, frm_pend_nxt;
  logic                 samp_a_r, samp_b_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, par_err_r, frm_err_r, ovr_r, busy_r;
  logic                 line_s, vote_s, at_vote_s, at_wrap_s, deliver_s, load_s, hshake_s;
  logic [CW-1:0]        cnt_inc_s;

  assign line_s    = sync2_r;
  assign vote_s    = maj3(samp_a_r, samp_b_r, line_s);
  assign at_vote_s = (cnt_r == CNT_VOTE);
  assign at_wrap_s = (cnt_r == CNT_LAST);
  assign cnt_inc_s = at_wrap_s ? '0 : cnt_r + CW'(1);
  assign hshake_s  = valid_r & rx.rxReady;
  assign load_s    = deliver_s & (~valid_r | rx.rxReady);

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx.serialIn;
      sync2_r <= sync1_r;
    end
  end

  // A start is only accepted after a real high has passed the synchronizer,
  // so a line that is already low when reset releases is not a start edge.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      fill_r  <= {fill_r[0], 1'b1};
      armed_r <= armed_r | (fill_r[1] & line_s);
    end
  end

  // Frame sequencing: next state, counters, shift register and pending errors.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    bit_cnt_nxt  = bit_cnt_r;
    stop_idx_nxt = stop_idx_r;
    shift_nxt    = shift_r;
    par_pend_nxt = par_pend_r;
    frm_pend_nxt = frm_pend_r;
    deliver_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt = '0;
        if (armed_r && !line_s) begin
          state_nxt    = START;
          cnt_nxt      = CW'(1);
          bit_cnt_nxt  = '0;
          stop_idx_nxt = 1'b0;
          par_pend_nxt = 1'b0;
          frm_pend_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        cnt_nxt = cnt_inc_s;
        if (at_vote_s && vote_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (at_wrap_s) begin
          state_nxt = DATA;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        cnt_nxt = cnt_inc_s;
        if (at_vote_s) begin
          shift_nxt   = {vote_s, shift_r[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt_r + BW'(1);
        end else if (at_wrap_s && (bit_cnt_r == BITS_LAST)) begin
          state_nxt   = AFTER_DAT;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = DATA;
        end
      end
      PARITY: begin
        cnt_nxt = cnt_inc_s;
        if (at_vote_s) begin
          par_pend_nxt = parity_bad(shift_r, vote_s, ODD_BIT);
        end else if (at_wrap_s) begin
          state_nxt = STOP;
        end else begin
          state_nxt = PARITY;
        end
      end
      STOP: begin
        cnt_nxt = cnt_inc_s;
        if (at_vote_s) begin
          frm_pend_nxt = frm_pend_r | ~vote_s;
          if (stop_idx_r == STOP_LAST) begin
            // Leave at the vote, not the bit end, so back-to-back frames are caught.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            deliver_s = 1'b1;
          end else begin
            state_nxt = STOP;
          end
        end else if (at_wrap_s) begin
          stop_idx_nxt = stop_idx_r + 1'b1;
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= '0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      par_pend_r <= 1'b0;
      frm_pend_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      stop_idx_r <= stop_idx_nxt;
      shift_r    <= shift_nxt;
      par_pend_r <= par_pend_nxt;
      frm_pend_r <= frm_pend_nxt;
    end
  end

  // Early two of the three vote samples; the third is the live line at the vote.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      if (cnt_r == CNT_PRE) samp_a_r <= line_s;
      if (cnt_r == CNT_MID) samp_b_r <= line_s;
    end
  end

  // Hold register, handshake and sticky overrun.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      ovr_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt != IDLE);
      if (load_s) begin
        data_r    <= shift_r;
        par_err_r <= par_pend_r & HAS_PAR;
        frm_err_r <= frm_pend_nxt;
        valid_r   <= 1'b1;
      end else if (hshake_s) begin
        valid_r <= 1'b0;
      end
      if (deliver_s && !load_s) begin
        ovr_r <= 1'b1;
      end else if (hshake_s) begin
        ovr_r <= 1'b0;
      end
    end
  end

  assign rx.rxData     = data_r;
  assign rx.rxValid    = valid_r;
  assign rx.parityErr  = par_err_r;
  assign rx.frameErr   = frm_err_r;
  assign rx.overrunErr = ovr_r;
  assign rx.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomized bench for uart_rx_param: two instances (8N1 and 8E2), a timeline
// model of when each frame must appear, and literal checks of directed cases.
module tb_uart_rx_param;
  localparam int OS = 8;
  localparam int H  = OS / 2;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;
  int   edge_no = 0;
  bit   chk_en = 1'b0;

  logic ser[2];
  logic rdy[2];
  bit   rnd_rdy[2];
  bit   abort[2];
  int   pe_of[2] = '{0, 1};
  int   sb_of[2] = '{1, 2};

  // Frame currently on each line: edges where busy must rise and the frame resolves.
  bit       fr_act[2];
  bit       fr_false[2];
  int       fr_rise[2];
  int       fr_end[2];
  logic [7:0] fr_data[2];
  logic     fr_pe[2];
  logic     fr_fe[2];

  logic [7:0] a_data[2];
  logic       a_valid[2], a_pe[2], a_fe[2], a_ov[2], a_busy[2];
  logic [7:0] last_data[2];
  logic       last_pe[2], last_fe[2];
  int         vcnt[2];

  uart_rx_param_if #(.DATA_BITS(DB)) bus0 ();
  uart_rx_param_if #(.DATA_BITS(DB)) bus1 ();

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.sampleClk(clk), .rst_b(rst_b), .rx(bus0));
  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_dut1 (.sampleClk(clk), .rst_b(rst_b), .rx(bus1));

  assign bus0.serialIn = ser[0];
  assign bus0.rxReady  = rdy[0];
  assign bus1.serialIn = ser[1];
  assign bus1.rxReady  = rdy[1];
  assign a_data[0] = bus0.rxData;   assign a_data[1] = bus1.rxData;
  assign a_valid[0] = bus0.rxValid; assign a_valid[1] = bus1.rxValid;
  assign a_pe[0] = bus0.parityErr;  assign a_pe[1] = bus1.parityErr;
  assign a_fe[0] = bus0.frameErr;   assign a_fe[1] = bus1.frameErr;
  assign a_ov[0] = bus0.overrunErr; assign a_ov[1] = bus1.overrunErr;
  assign a_busy[0] = bus0.busy;     assign a_busy[1] = bus1.busy;

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) edge_no <= edge_no + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [7:0] e_data = 8'h00;
    logic e_valid = 1'b0, e_pe = 1'b0, e_fe = 1'b0, e_ov = 1'b0, e_busy = 1'b0;

    // Expected outputs from the frame timeline and the consumer's ready.
    always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        e_data <= 8'h00; e_valid <= 1'b0; e_pe <= 1'b0; e_fe <= 1'b0;
        e_ov <= 1'b0; e_busy <= 1'b0;
      end else begin
        if (fr_act[g] && fr_rise[g] == edge_no + 1) e_busy <= 1'b1;
        if (fr_act[g] && fr_end[g] == edge_no + 1 && !fr_false[g]) begin
          e_busy <= 1'b0;
          if (!e_valid || rdy[g]) begin
            e_data <= fr_data[g]; e_pe <= fr_pe[g]; e_fe <= fr_fe[g]; e_valid <= 1'b1;
            if (e_valid) e_ov <= 1'b0;
          end else begin
            e_ov <= 1'b1;
          end
        end else begin
          if (fr_act[g] && fr_end[g] == edge_no + 1) e_busy <= 1'b0;
          if (e_valid && rdy[g]) begin
            e_valid <= 1'b0; e_ov <= 1'b0;
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (a_valid[g] === 1'b1) begin
        last_data[g] = a_data[g]; last_pe[g] = a_pe[g]; last_fe[g] = a_fe[g];
        vcnt[g]++;
      end
      if (chk_en) begin
        chk($sformatf("u%0d_valid", g), a_valid[g], e_valid);
        chk($sformatf("u%0d_busy", g), a_busy[g], e_busy);
        chk($sformatf("u%0d_overrun", g), a_ov[g], e_ov);
        if (e_valid) begin
          chk($sformatf("u%0d_data", g), a_data[g], e_data);
          chk($sformatf("u%0d_parity", g), a_pe[g], e_pe);
          chk($sformatf("u%0d_frame", g), a_fe[g], e_fe);
        end
      end
    end
  end

  // Random ready when enabled; otherwise the main sequence drives ready itself.
  for (genvar g = 0; g < 2; g++) begin : g_rdy
    initial forever begin
      @(negedge clk);
      if (rnd_rdy[g]) rdy[g] = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int i, input logic [7:0] d, input bit bad_par, input int bad_stop);
    logic fbits [0:15];
    int nb, pe, sb;
    logic low;
    pe = pe_of[i]; sb = sb_of[i]; nb = 1 + DB + pe + sb;
    fbits[0] = 1'b0;
    for (int b = 0; b < DB; b++) fbits[1 + b] = d[b];
    if (pe == 1) fbits[1 + DB] = (^d) ^ bad_par;
    for (int s = 0; s < sb; s++) fbits[1 + DB + pe + s] = 1'b1;
    @(negedge clk);
    fr_false[i] = 1'b0; fr_data[i] = d; fr_pe[i] = (pe == 1) && bad_par;
    fr_fe[i] = (bad_stop != 0);
    fr_rise[i] = edge_no + 3;
    fr_end[i] = edge_no + 4 + H + (nb - 1) * OS;
    fr_act[i] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < OS; c++) begin
        if (abort[i]) begin
          ser[i] = 1'b1;
          return;
        end
        // A bad stop bit is low across the vote window, then idles high.
        low = (bad_stop != 0) && (b == DB + pe + bad_stop) && (c < H + 2);
        ser[i] = low ? 1'b0 : fbits[b];
        @(negedge clk);
      end
    end
    ser[i] = 1'b1;
  endtask

  task automatic false_start(input int i, input int len);
    @(negedge clk);
    fr_false[i] = 1'b1;
    fr_rise[i] = edge_no + 3;
    fr_end[i] = edge_no + 4 + H;
    fr_act[i] = 1'b1;
    ser[i] = 1'b0;
    repeat (len) @(negedge clk);
    ser[i] = 1'b1;
    repeat (OS + 4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, i, k, bs;
    ser[0] = 1'b1; ser[1] = 1'b1; rdy[0] = 1'b0; rdy[1] = 1'b0;
    rnd_rdy[0] = 1'b0; rnd_rdy[1] = 1'b0; abort[0] = 1'b0; abort[1] = 1'b0;
    fr_act[0] = 1'b0; fr_act[1] = 1'b0; vcnt[0] = 0; vcnt[1] = 0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", a_valid[0], 1'b0);
    chk("rst_busy", a_busy[0], 1'b0);
    chk("rst_data", a_data[0], 8'h00);
    chk("rst_flags", {a_pe[0], a_fe[0], a_ov[0]}, 3'b000);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;

    // 8N1 frame with ready held high: one-cycle valid pulse.
    rdy[0] = 1'b1;
    v0 = vcnt[0];
    send(0, 8'h55, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("p55_data", last_data[0], 8'h55);
    chk("p55_flags", {last_pe[0], last_fe[0]}, 2'b00);
    chk("p55_pulse", vcnt[0] - v0, 1);

    v0 = vcnt[0];
    false_start(0, 2);
    chk("fs_busy", a_busy[0], 1'b0);
    chk("fs_novalid", vcnt[0] - v0, 0);

    send(0, 8'hA5, 1'b0, 1);
    repeat (4) @(negedge clk);
    chk("pa5_data", last_data[0], 8'hA5);
    chk("pa5_frame", last_fe[0], 1'b1);

    // Overrun: second frame dropped while the first is held.
    rdy[0] = 1'b0;
    send(0, 8'h11, 1'b0, 0);
    send(0, 8'h22, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("ovr_data", a_data[0], 8'h11);
    chk("ovr_flag", a_ov[0], 1'b1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    @(negedge clk);
    chk("ovr_valid_clr", a_valid[0], 1'b0);
    chk("ovr_flag_clr", a_ov[0], 1'b0);

    // Even parity, 0x03 with parity bit 1.
    rdy[1] = 1'b1;
    send(1, 8'h03, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("p03_data", last_data[1], 8'h03);
    chk("p03_parity", last_pe[1], 1'b1);
    chk("p03_frame", last_fe[1], 1'b0);
    send(1, 8'h96, 1'b0, 2);
    repeat (4) @(negedge clk);
    chk("p96_flags", {last_pe[1], last_fe[1]}, 2'b01);

    // Reset mid-DATA, released while the line is still low.
    rdy[0] = 1'b1;
    fork
      send(0, 8'h00, 1'b0, 0);
      begin
        repeat (30) @(negedge clk);
        rst_b = 1'b0;
        fr_act[0] = 1'b0;
        #1;
        chk("mrst_busy", a_busy[0], 1'b0);
        chk("mrst_outs", {a_valid[0], a_pe[0], a_fe[0], a_ov[0], a_data[0]}, 12'h000);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (8) @(negedge clk);
        abort[0] = 1'b1;
      end
    join
    abort[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_idle", a_busy[0], 1'b0);
    send(0, 8'h3C, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("p3c_data", last_data[0], 8'h3C);

    // Random traffic across both instances.
    for (int n = 0; n < 160; n++) begin
      i = $urandom_range(0, 1);
      k = $urandom_range(0, 2);
      rnd_rdy[i] = (k == 2);
      if (k != 2) rdy[i] = (k == 1);
      if ($urandom_range(0, 7) == 0) begin
        false_start(i, $urandom_range(1, 3));
      end else begin
        bs = ($urandom_range(0, 5) == 0) ? $urandom_range(1, sb_of[i]) : 0;
        send(i, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), bs);
        repeat ($urandom_range(0, 2 * OS)) @(negedge clk);
      end
    end
    rnd_rdy[0] = 1'b0; rnd_rdy[1] = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
